// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: single-port arbiter and sequencer in front of data_memory.
// The store-commit path and the load unit share the memory. The arbiter takes
// one request at a time, holds the memory request lines for the whole access,
// and returns load data with the requester's tag.
//
// Optional feature: define DMEM_ARB_STARVE_GUARD_EN to build the store-streak
// counter. Once MAX_STORE_STREAK stores have been granted while a load waits,
// the load is granted over a pending store. Without the macro, stores have
// strict priority and loads may starve.
//
// Handshake: a request transfers on the rising clk edge where valid && ready.
// ready is combinational and is high only in IDLE, only for the winning
// requester, and never while reset_n is low. The requester must keep valid and
// its payload stable until that transfer. It may change them freely after the
// transfer edge, because the payload is captured into holding registers.
//
// Debug: dbg_state exposes the FSM state encoding.
module dmem_port_arbiter #(
    parameter int TAG_W            = 4,
    parameter int MAX_STORE_STREAK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    // store request
    input  logic             st_req_valid,
    output logic             st_req_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             st_byte,
    output logic             st_done,
    // load request / response
    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [31:0]      ld_addr,
    input  logic             ld_byte,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             ld_resp_valid,
    output logic [31:0]      ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    // data_memory request / completion
    output logic             mem_write_enable,
    output logic             mem_read_enable,
    output logic [31:0]      mem_write_address,
    output logic [31:0]      mem_read_address,
    output logic [31:0]      mem_write_value,
    output logic             mem_store_byte,
    output logic             mem_load_byte,
    input  logic [31:0]      mem_read_value,
    input  logic             mem_write_valid,
    input  logic             mem_read_valid,
    // debug
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_BUSY = 3'd1,
        RD_BUSY = 3'd2,
        RESP    = 3'd3,
        WDONE   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        hold_addr;
    logic [31:0]        hold_data;
    logic               hold_byte;
    logic [TAG_W-1:0]   hold_tag;
    logic               load_prio;
    logic               st_accept;
    logic               ld_accept;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = $clog2(MAX_STORE_STREAK + 1);
    logic [STREAK_W-1:0] streak;

    // A waiting load wins once the store streak has reached its limit.
    assign load_prio = ld_req_valid && (streak == STREAK_W'(MAX_STORE_STREAK));

    // Count stores granted while a load waits; a load grant or an IDLE cycle with no load pending clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (ld_accept || !ld_req_valid) begin
                streak <= '0;
            end else if (st_accept && (streak != STREAK_W'(MAX_STORE_STREAK))) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end
`else
    logic unused_streak_cfg;
    assign unused_streak_cfg = (MAX_STORE_STREAK > 0);
    assign load_prio         = 1'b0;
`endif

    // Grant: only in IDLE and out of reset; store first unless the streak guard hands priority to the load.
    always_comb begin
        st_req_ready = 1'b0;
        ld_req_ready = 1'b0;
        if (reset_n && (state == IDLE)) begin
            st_req_ready = st_req_valid && !load_prio;
            ld_req_ready = ld_req_valid && (!st_req_valid || load_prio);
        end
    end

    assign st_accept = st_req_valid && st_req_ready;
    assign ld_accept = ld_req_valid && ld_req_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept in IDLE, wait for the matching completion, pulse the result for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (st_accept) begin
                    state_nxt = WR_BUSY;
                end else if (ld_accept) begin
                    state_nxt = RD_BUSY;
                end
            end
            WR_BUSY: begin
                if (mem_write_valid) begin
                    state_nxt = WDONE;
                end
            end
            RD_BUSY: begin
                if (mem_read_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            WDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted request so the requester is free after the accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_addr <= '0;
            hold_data <= '0;
            hold_byte <= 1'b0;
            hold_tag  <= '0;
        end else if (st_accept) begin
            hold_addr <= st_addr;
            hold_data <= st_data;
            hold_byte <= st_byte;
        end else if (ld_accept) begin
            hold_addr <= ld_addr;
            hold_byte <= ld_byte;
            hold_tag  <= ld_tag;
        end
    end

    // Load response registers: updated only on read completion, held until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_resp_data <= '0;
            ld_resp_tag  <= '0;
        end else if ((state == RD_BUSY) && mem_read_valid) begin
            ld_resp_data <= mem_read_value;
            ld_resp_tag  <= hold_tag;
        end
    end

    // Enables drop in the completion cycle so the memory's latency counter restarts at zero.
    assign mem_write_enable  = (state == WR_BUSY) && !mem_write_valid;
    assign mem_read_enable   = (state == RD_BUSY) && !mem_read_valid;
    assign mem_write_address = hold_addr;
    assign mem_read_address  = hold_addr;
    assign mem_write_value   = hold_data;
    assign mem_store_byte    = hold_byte;
    assign mem_load_byte     = hold_byte;

    assign st_done       = (state == WDONE);
    assign ld_resp_valid = (state == RESP);
    assign dbg_state     = state;

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Single-port arbiter and sequencer for the `data_memory` block. It shares the memory between the load unit and the store-commit path. It accepts one request at a time through valid/ready handshakes, drives the memory's enable/address/data lines for the whole access latency, and returns load data with the requester's tag. It sits between the LSQ/commit logic and `data_memory`; it is the only driver of the memory's request ports.

## Interface
- `TAG_W`, 4: width of the load tag.
- `MAX_STORE_STREAK`, 4: consecutive store grants allowed while a load waits. Used only under `DMEM_ARB_STARVE_GUARD_EN`.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `st_req_valid` in 1: store request.
- `st_req_ready` out 1: store accepted when valid&&ready.
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data.
- `st_byte` in 1: byte store.
- `st_done` out 1: one-cycle pulse, store written.
- `ld_req_valid` in 1: load request.
- `ld_req_ready` out 1: load accepted when valid&&ready.
- `ld_addr` in 32: load byte address.
- `ld_byte` in 1: byte load.
- `ld_tag` in TAG_W: load tag.
- `ld_resp_valid` out 1: one-cycle pulse, load data ready.
- `ld_resp_data` out 32: load data.
- `ld_resp_tag` out TAG_W: tag of the completed load.
- `mem_write_enable`, `mem_read_enable` out 1: memory enables.
- `mem_write_address`, `mem_read_address` out 32: memory addresses.
- `mem_write_value` out 32: memory write data.
- `mem_store_byte`, `mem_load_byte` out 1: byte-size selects.
- `mem_read_value` in 32: memory read data.
- `mem_write_valid`, `mem_read_valid` in 1: memory completion pulses.

## Operation
- **States**
  - `IDLE`
  - `WR_BUSY`
  - `RD_BUSY`
  - `RESP`: registers the load response.
  - `WDONE`: registers `st_done`.
- **Grant (IDLE only, combinational)**
  - Store wins if `st_req_valid`.
  - Otherwise load wins if `ld_req_valid`.
  - Only the winner sees ready=1.
  - Both ready=0 in every non-IDLE state.
- **Accept**
  - Latch addr, data, size and tag into holding registers.
  - Go to `WR_BUSY` or `RD_BUSY`.
  - Requester inputs may change after the accept edge.
- **Memory drive**
  - `mem_write_enable = (state==WR_BUSY) && !mem_write_valid`.
  - `mem_read_enable = (state==RD_BUSY) && !mem_read_valid`.
  - Gating the enable in the completion cycle keeps the memory's latency counter at 0 for the next access.
  - The two enables are never high together.
  - Address, data and size outputs come from the holding registers and stay stable for the whole access.
- **Completion**
  - `WR_BUSY` + `mem_write_valid` -> `WDONE`.
  - `RD_BUSY` + `mem_read_valid` -> `RESP`, capturing `mem_read_value` and the tag.
  - `RESP` and `WDONE` pulse their outputs for one cycle, then return to `IDLE`.
- **Stray pulses**: `mem_*_valid` arriving in any other state, or of the wrong type, is ignored.
- **Streak counter**
  - Increments on each store accept while `ld_req_valid` = 1.
  - Clears on a load accept, or on any IDLE cycle with `ld_req_valid` = 0.
  - Saturates at `MAX_STORE_STREAK`.

## Timing
- **Reset values**
  - State `IDLE`; streak 0.
  - All outputs 0: both readys, `st_done`, `ld_resp_valid`, `ld_resp_data`, `ld_resp_tag`, all `mem_*` outputs.
- **Reset mid-operation**: aborts the access immediately and returns to `IDLE`. No `st_done` or `ld_resp_valid` is issued for the aborted request.
- **Latency** (accept edge = t0, memory latency = L)
  - Memory enable high for cycles t0+1..t0+L.
  - `mem_*_valid` seen in cycle t0+L+1; enable low in that cycle.
  - `st_done` / `ld_resp_valid` high in cycle t0+L+2.
  - Next accept possible at the edge ending cycle t0+L+3, i.e. throughput of one access per L+3 cycles.
- **Response outputs**: `ld_resp_data` and `ld_resp_tag` hold their value until the next load response.
- **Simultaneous requests**: both valid in the same IDLE cycle -> the store is granted (subject to the starvation guard). The load stays pending with ready=0 and must keep valid high.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined:
  - When streak == `MAX_STORE_STREAK` and `ld_req_valid` = 1, the load is granted over a pending store.
  - The streak then clears.
- Not defined:
  - Strict store priority; the streak counter is not built.
  - Loads may starve indefinitely.

## Test plan
- **Single store**: store addr 0x10, data 0xAABBCCDD, word, L=10 -> exactly 10 cycles of `mem_write_enable`; `st_done` in cycle t0+12. A following word load of 0x10 returns 0xAABBCCDD with its tag.
- **Byte load**: byte store 0x5A to 0x21, then byte load of 0x21 with tag 7 -> `ld_resp_data` = 0x0000005A, `ld_resp_tag` = 7.
- **Simultaneous requests**: load and store both valid in the same cycle -> store serviced first; load accepted at t0+L+3; enables never overlap.
- **Starvation guard** (macro defined, MAX=4): continuous stores plus a pending load -> load granted after the 4th store. With the macro undefined -> load granted only once `st_req_valid` falls.
- **Reset mid-read**: `reset_n` low at cycle 5 of a read -> all outputs 0 immediately, no `ld_resp_valid`; a fresh request after release completes normally in L+2 cycles.
- **Stray completion**: `mem_read_valid` pulsed while in `IDLE` -> no response and no state change.
